// File: rtl/tracer_pkg.sv
// Shared types and constants for the trace dump engine: FSM states, AXI encodings
// and the 4 KB page geometry that bounds every burst.
package tracer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_DONE
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int PAGE_BYTES = 4096;
  localparam int BEAT_BYTES = 8;

  // SLVERR and DECERR both carry bit 1; OKAY and EXOKAY do not.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/trace_dump_writer_if.sv
// Trace-record stream plus AXI4 write channels of the dump engine.
// The engine uses the master modport; memory and stream source sit on slave.
interface trace_dump_writer_if #(
  parameter int AddrWidth = 64
) ();

  logic [63:0]          s_tdata;
  logic                 s_tvalid;
  logic                 s_tready;

  logic [AddrWidth-1:0] m_awaddr;
  logic [7:0]           m_awlen;
  logic [2:0]           m_awsize;
  logic [1:0]           m_awburst;
  logic                 m_awvalid;
  logic                 m_awready;

  logic [63:0]          m_wdata;
  logic [7:0]           m_wstrb;
  logic                 m_wlast;
  logic                 m_wvalid;
  logic                 m_wready;

  logic [1:0]           m_bresp;
  logic                 m_bvalid;
  logic                 m_bready;

  modport master (
    input  s_tdata, s_tvalid,
    output s_tready,
    output m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    input  m_awready,
    output m_wdata, m_wstrb, m_wlast, m_wvalid,
    input  m_wready,
    input  m_bresp, m_bvalid,
    output m_bready
  );

  modport slave (
    output s_tdata, s_tvalid,
    input  s_tready,
    input  m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
    output m_awready,
    input  m_wdata, m_wstrb, m_wlast, m_wvalid,
    output m_wready,
    output m_bresp, m_bvalid,
    input  m_bready
  );

endinterface

// File: rtl/trace_dump_writer_burst_len.sv
// Beats in the next burst: the smallest of records left, the burst cap and the
// beats that fit before the next 4 KB boundary.
module trace_burst_len
  import tracer_pkg::*;
#(
  parameter int MaxBurstLen = 16,
  parameter int CountWidth  = 31
) (
  input  logic [11:0]           page_off,
  input  logic [CountWidth-1:0] remaining,
  output logic [8:0]            beats
);

  logic [31:0] page_beats;
  logic [31:0] limit;

  // NOTE: every variable gets a value at the top of the block, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    page_beats = (32'(PAGE_BYTES) - 32'(page_off)) / 32'(BEAT_BYTES);
    limit      = 32'(MaxBurstLen);
    if (page_beats < limit) limit = page_beats;
    if (32'(remaining) < limit) limit = 32'(remaining);
    beats = 9'(limit);
  end

endmodule

// File: rtl/trace_dump_writer.sv
// Dump engine: drains num_entries trace records from the stream into host memory
// as 4 KB-safe AXI4 INCR bursts, one burst outstanding, under ap_ctrl_hs control.
module trace_dump_writer
  import tracer_pkg::*;
#(
  parameter int AddrWidth   = 64,
  parameter int MaxBurstLen = 16,
  parameter int CountWidth  = 31
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_ready,
  output logic                  ap_idle,
  input  logic [63:0]           trace_dump,
  output logic [31:0]           tracer_return_code,
  input  logic [CountWidth-1:0] num_entries,
  trace_dump_writer_if.master   bus
);

  state_e                state_q, state_d;
  logic [AddrWidth-1:0]  addr_q, addr_d;
  logic [CountWidth-1:0] remaining_q, remaining_d;
  logic [CountWidth-1:0] written_q, written_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic [31:0]           ret_q, ret_d;
  logic [8:0]            beats;
  logic                  last_beat;

  // addr_q and remaining_q only move in B, so beats is stable across a whole burst.
  trace_burst_len #(
    .MaxBurstLen(MaxBurstLen),
    .CountWidth (CountWidth)
  ) u_burst_len (
    .page_off (addr_q[11:0]),
    .remaining(remaining_q),
    .beats    (beats)
  );

  assign last_beat          = (beat_cnt_q == beats - 9'd1);
  assign bus.m_awaddr       = addr_q;
  assign bus.m_awlen        = 8'(beats - 9'd1);
  assign bus.m_awsize       = AXI_SIZE_8B;
  assign bus.m_awburst      = AXI_BURST_INCR;
  assign bus.m_wdata        = bus.s_tdata;
  assign bus.m_wstrb        = 8'hFF;
  assign bus.m_wlast        = (state_q == ST_W) && last_beat;
  assign tracer_return_code = ret_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    written_d     = written_q;
    beat_cnt_d    = beat_cnt_q;
    ret_d         = ret_q;
    ap_idle       = 1'b0;
    ap_done       = 1'b0;
    ap_ready      = 1'b0;
    bus.m_awvalid = 1'b0;
    bus.m_wvalid  = 1'b0;
    bus.s_tready  = 1'b0;
    bus.m_bready  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          addr_d      = AddrWidth'({trace_dump[63:3], 3'b000});
          remaining_d = num_entries;
          written_d   = '0;
          beat_cnt_d  = '0;
          ret_d       = '0;
          state_d     = (num_entries == '0) ? ST_DONE : ST_AW;
        end
      end

      ST_AW: begin
        bus.m_awvalid = 1'b1;
        if (bus.m_awready) state_d = ST_W;
      end

      // Zero-latency pass-through: the stream sees the W channel's ready directly.
      ST_W: begin
        bus.m_wvalid = bus.s_tvalid;
        bus.s_tready = bus.m_wready;
        if (bus.s_tvalid && bus.m_wready) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = ST_B;
          end else begin
            beat_cnt_d = beat_cnt_q + 9'd1;
          end
        end
      end

      ST_B: begin
        bus.m_bready = 1'b1;
        if (bus.m_bvalid) begin
          if (resp_is_err(bus.m_bresp)) begin
            ret_d   = {1'b1, 31'(written_q)};
            state_d = ST_DONE;
          end else begin
            written_d   = written_q + CountWidth'(beats);
            remaining_d = remaining_q - CountWidth'(beats);
            addr_d      = addr_q + AddrWidth'({beats, 3'b000});
            ret_d       = {1'b0, 31'(written_d)};
            state_d     = (remaining_d == '0) ? ST_DONE : ST_AW;
          end
        end
      end

      ST_DONE: begin
        ap_done  = 1'b1;
        ap_ready = 1'b1;
        state_d  = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      written_q   <= '0;
      beat_cnt_q  <= '0;
      ret_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      written_q   <= written_d;
      beat_cnt_q  <= beat_cnt_d;
      ret_q       <= ret_d;
    end
  end

endmodule

// File: tb/tb_trace_dump_writer.sv
// Randomized bench for trace_dump_writer: an AXI memory/stream environment with
// random stalls, checked against a burst-plan model derived from the dump rules.
module tb_trace_dump_writer;

  localparam int ADDR_W    = 64;
  localparam int MAX_BURST = 16;
  localparam int CNT_W     = 31;
  localparam int LIMIT     = 4000;

  typedef struct {
    logic [63:0] addr;
    int          beats;
  } burst_t;

  logic             clk;
  logic             reset;
  logic             ap_start;
  logic             ap_done;
  logic             ap_ready;
  logic             ap_idle;
  logic [63:0]      trace_dump;
  logic [31:0]      tracer_return_code;
  logic [CNT_W-1:0] num_entries;

  trace_dump_writer_if #(.AddrWidth(ADDR_W)) bus ();

  trace_dump_writer #(
    .AddrWidth  (ADDR_W),
    .MaxBurstLen(MAX_BURST),
    .CountWidth (CNT_W)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .ap_start          (ap_start),
    .ap_done           (ap_done),
    .ap_ready          (ap_ready),
    .ap_idle           (ap_idle),
    .trace_dump        (trace_dump),
    .tracer_return_code(tracer_return_code),
    .num_entries       (num_entries),
    .bus               (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model state (per dump).
  burst_t      exp_aw_q[$];
  logic [63:0] exp_data_q[$];
  logic [63:0] src_q[$];
  int          exp_n_aw, exp_consumed, exp_left;
  logic [31:0] exp_code;

  // Environment knobs and observations.
  int gap_pct = 0, stall_pct = 0, max_b_delay = 0, err_burst_cfg = 0;
  bit flush_req = 0;
  int aw_seen = 0, w_seen = 0, b_count = 0;

  // Memory slave, stream source and channel monitor.
  initial begin : env
    bit          aw_f, w_f, b_f, s_f;
    bit          aw_pend;
    logic [63:0] aw_addr_prev;
    logic [7:0]  aw_len_prev;
    int          cur_len, cur_beat, b_wait;
    burst_t      e;
    aw_pend = 0; aw_addr_prev = '0; aw_len_prev = '0;
    cur_len = 0; cur_beat = 0; b_wait = -1;
    bus.s_tdata = '0; bus.s_tvalid = 0; bus.m_awready = 0; bus.m_wready = 0;
    bus.m_bresp = 2'b00; bus.m_bvalid = 0;
    forever begin
      @(negedge clk);
      aw_f = bus.m_awvalid && bus.m_awready;
      w_f  = bus.m_wvalid && bus.m_wready;
      b_f  = bus.m_bvalid && bus.m_bready;
      s_f  = bus.s_tvalid && bus.s_tready;
      if (!reset) begin
        if (aw_pend) begin
          check("awvalid_hold", bus.m_awvalid, 1'b1);
          check("awaddr_hold", bus.m_awaddr, aw_addr_prev);
          check("awlen_hold", bus.m_awlen, aw_len_prev);
        end
        aw_pend      = bus.m_awvalid && !bus.m_awready;
        aw_addr_prev = bus.m_awaddr;
        aw_len_prev  = bus.m_awlen;
        if (aw_f) begin
          aw_seen++;
          check("awsize", bus.m_awsize, 3'b011);
          check("awburst", bus.m_awburst, 2'b01);
          if (exp_aw_q.size() > 0) begin
            e = exp_aw_q.pop_front();
            check("awaddr", bus.m_awaddr, e.addr);
            check("awlen", bus.m_awlen, 64'(e.beats - 1));
            cur_len = e.beats;
          end else begin
            cur_len = int'(bus.m_awlen) + 1;
          end
          cur_beat = 0;
        end
        if (w_f) begin
          w_seen++;
          if (exp_data_q.size() > 0) check("wdata", bus.m_wdata, exp_data_q.pop_front());
          check("wlast", bus.m_wlast, (cur_beat == cur_len - 1));
          check("wstrb", bus.m_wstrb, 8'hFF);
          cur_beat++;
        end
      end
      @(posedge clk);
      #1;
      if (reset || flush_req) begin
        src_q.delete();
        bus.s_tvalid = 0; bus.m_bvalid = 0;
        aw_pend = 0; cur_beat = 0; cur_len = 0; b_wait = -1;
        aw_seen = 0; w_seen = 0; b_count = 0;
        flush_req = 0;
      end else begin
        if (s_f && src_q.size() > 0) void'(src_q.pop_front());
        if (!bus.s_tvalid || s_f) begin
          if (src_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
            bus.s_tvalid = 1; bus.s_tdata = src_q[0];
          end else begin
            bus.s_tvalid = 0;
          end
        end
        bus.m_awready = ($urandom_range(99) >= stall_pct);
        bus.m_wready  = ($urandom_range(99) >= stall_pct);
        if (b_f) begin
          bus.m_bvalid = 0;
          b_count++;
        end
        if (w_f && cur_beat == cur_len) b_wait = $urandom_range(max_b_delay);
        if (b_wait == 0 && !bus.m_bvalid) begin
          bus.m_bvalid = 1;
          bus.m_bresp  = (b_count + 1 == err_burst_cfg) ? 2'b10 : 2'($urandom_range(1));
          b_wait = -1;
        end else if (b_wait > 0) begin
          b_wait--;
        end
      end
    end
  end

  // Plan the bursts from the dump rules and load the stream with fresh records.
  task automatic prep_dump(input logic [63:0] base, input int n, input int errb);
    logic [63:0] a, rec;
    int rem, b, page, idx, wr;
    bit err;
    flush_req = 1;
    repeat (2) @(posedge clk);
    exp_aw_q.delete();
    exp_data_q.delete();
    for (int i = 0; i < n; i++) begin
      rec = {$urandom, $urandom};
      src_q.push_back(rec);
      exp_data_q.push_back(rec);
    end
    a = base & ~64'h7; rem = n; idx = 0; wr = 0; err = 0; exp_consumed = 0;
    while (rem > 0) begin
      page = (4096 - int'(a % 4096)) / 8;
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > page) b = page;
      exp_aw_q.push_back('{addr: a, beats: b});
      idx++;
      exp_consumed += b;
      if (idx == errb) begin
        err = 1;
        break;
      end
      wr += b; a += 64'(b * 8); rem -= b;
    end
    exp_n_aw      = exp_aw_q.size();
    exp_left      = n - exp_consumed;
    exp_code      = {err, 31'(wr)};
    err_burst_cfg = errb;
    trace_dump    = base;
    num_entries   = CNT_W'(n);
  endtask

  task automatic launch_and_wait(input string tag, output int cyc);
    bit got;
    @(posedge clk);
    #1 ap_start = 1;
    got = 0; cyc = 0;
    while (!got && cyc < LIMIT) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (ap_done) got = 1;
    end
    check({tag, "_done_seen"}, got, 1'b1);
    if (got) begin
      check({tag, "_ap_ready"}, ap_ready, 1'b1);
      check({tag, "_code"}, tracer_return_code, exp_code);
      @(posedge clk);
      #1 ap_start = 0;
      @(negedge clk);
      check({tag, "_done_pulse"}, ap_done, 1'b0);
      check({tag, "_idle"}, ap_idle, 1'b1);
      check({tag, "_code_hold"}, tracer_return_code, exp_code);
      check({tag, "_aw_count"}, aw_seen, exp_n_aw);
      check({tag, "_beats"}, w_seen, exp_consumed);
      check({tag, "_left"}, src_q.size(), exp_left);
    end else begin
      ap_start = 0;
    end
  endtask

  task automatic run_dump(input string tag, input logic [63:0] base, input int n, input int errb, output int cyc);
    prep_dump(base, n, errb);
    launch_and_wait(tag, cyc);
  endtask

  initial begin : main
    int cyc;
    logic [63:0] base;
    reset = 1; ap_start = 0; trace_dump = '0; num_entries = '0;
    #12;
    check("rst_idle", ap_idle, 1'b1);
    check("rst_done", ap_done, 1'b0);
    check("rst_ready", ap_ready, 1'b0);
    check("rst_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.s_tready}, 4'b0);
    check("rst_code", tracer_return_code, 32'h0);
    @(negedge clk);
    reset = 0;

    run_dump("t1", 64'h1000, 0, 0, cyc);
    check("t1_latency", cyc, 1);
    check("t1_code", tracer_return_code, 32'h0000_0000);

    run_dump("t2", 64'h1000, 40, 0, cyc);
    check("t2_code", tracer_return_code, 32'h0000_0028);

    run_dump("t3", 64'h1FF0, 5, 0, cyc);
    check("t3_code", tracer_return_code, 32'h0000_0005);

    gap_pct = 30; stall_pct = 40; max_b_delay = 5;
    base = {32'h0, $urandom} & ~64'h7;
    run_dump("t4", base, 100, 0, cyc);

    gap_pct = 0; stall_pct = 0; max_b_delay = 2;
    run_dump("t5", 64'h1000, 40, 2, cyc);
    check("t5_code", tracer_return_code, 32'h8000_0010);

    gap_pct = 25; stall_pct = 30; max_b_delay = 4;
    for (int i = 0; i < 4; i++) begin
      base = {$urandom, 20'h0, 12'($urandom_range(12'hF00, 12'hFFF))};
      run_dump("rnd", base, $urandom_range(1, 50), $urandom_range(0, 3), cyc);
    end

    // Reset in the middle of a W phase, then a fresh dump must work.
    gap_pct = 0; stall_pct = 0; max_b_delay = 0;
    prep_dump(64'h3000, 40, 0);
    @(posedge clk);
    #1 ap_start = 1;
    cyc = 0;
    while (w_seen < 5 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("t6_reach_w", (w_seen >= 5), 1'b1);
    #2 reset = 1;
    ap_start = 0;
    #1;
    check("t6_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_bready, bus.s_tready}, 4'b0);
    check("t6_idle", ap_idle, 1'b1);
    check("t6_code", tracer_return_code, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    run_dump("t6_after", 64'h2FF8, 3, 0, cyc);
    check("t6_after_code", tracer_return_code, 32'h0000_0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
